// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: upstream decode handshake, writeback port and ALU-side outputs.
interface operand_fetch_if #(
  parameter int unsigned AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_we;
  logic          use_imm;
  logic          sign_ext;
  logic [15:0]   imm;
  logic [5:0]    funct;
  logic          flush;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   a;
  logic [31:0]   b;
  logic [5:0]    alu_op;
  logic [AW-1:0] out_rd_addr;
  logic          out_rd_we;

  modport slave (
    input  in_valid, rs_addr, rt_addr, rd_addr, rd_we, use_imm, sign_ext, imm, funct,
           flush, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, a, b, alu_op, out_rd_addr, out_rd_we
  );

  modport master (
    output in_valid, rs_addr, rt_addr, rd_addr, rd_we, use_imm, sign_ext, imm, funct,
           flush, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, a, b, alu_op, out_rd_addr, out_rd_we
  );
endinterface

// File: rtl/operand_fetch.sv
// MIPS operand-fetch stage: register file read with writeback bypass, registered ALU operands.
// Optional per-register pending scoreboard enabled by defining OPF_SCOREBOARD_EN.
module operand_fetch #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input logic            clk,
  input logic            reset_n,
  operand_fetch_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 16;
  localparam int unsigned FW = 6;

  logic [DW-1:0] regs_q [NREGS];

  logic          valid_q, valid_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [FW-1:0] op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          we_q, we_d;

  logic          wb_live_c;
  logic          accept_c;
  logic          hazard_c;
  logic [DW-1:0] rs_val_c;
  logic [DW-1:0] rt_val_c;
  logic [DW-1:0] imm_ext_c;

  assign wb_live_c = bus.wb_en && (bus.wb_addr != '0);

  // Source reads: r0 reads zero, a live writeback to the same address wins over the array
  always_comb begin
    rs_val_c = regs_q[bus.rs_addr];
    rt_val_c = regs_q[bus.rt_addr];
    if (bus.rs_addr == '0)
      rs_val_c = '0;
    else if (wb_live_c && (bus.wb_addr == bus.rs_addr))
      rs_val_c = bus.wb_data;
    if (bus.rt_addr == '0)
      rt_val_c = '0;
    else if (wb_live_c && (bus.wb_addr == bus.rt_addr))
      rt_val_c = bus.wb_data;
  end

  assign imm_ext_c = bus.sign_ext ? {{(DW-IW){bus.imm[IW-1]}}, bus.imm}
                                  : {{(DW-IW){1'b0}}, bus.imm};

`ifdef OPF_SCOREBOARD_EN
  logic [NREGS-1:0] pend_q, pend_d;
  logic             rs_busy_c, rt_busy_c, rd_busy_c;

  // A pending register is no longer busy if its writeback lands this cycle
  assign rs_busy_c = pend_q[bus.rs_addr] && !(bus.wb_en && (bus.wb_addr == bus.rs_addr));
  assign rt_busy_c = pend_q[bus.rt_addr] && !(bus.wb_en && (bus.wb_addr == bus.rt_addr));
  assign rd_busy_c = pend_q[bus.rd_addr] && !(bus.wb_en && (bus.wb_addr == bus.rd_addr));
  assign hazard_c  = rs_busy_c || (!bus.use_imm && rt_busy_c) || (bus.rd_we && rd_busy_c);

  // Set on accept is applied last so it wins over a same-edge clear
  always_comb begin
    pend_d = pend_q;
    if (bus.wb_en)
      pend_d[bus.wb_addr] = 1'b0;
    if (bus.flush && valid_q && we_q)
      pend_d[rd_q] = 1'b0;
    if (accept_c && bus.rd_we && (bus.rd_addr != '0))
      pend_d[bus.rd_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend_q <= '0;
    else          pend_q <= pend_d;
  end
`else
  assign hazard_c = 1'b0;
`endif

  assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready) && !hazard_c;
  assign accept_c     = bus.in_valid && bus.in_ready;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    we_d    = we_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept_c) begin
      valid_d = 1'b1;
      a_d     = rs_val_c;
      b_d     = bus.use_imm ? imm_ext_c : rt_val_c;
      op_d    = bus.funct;
      rd_d    = bus.rd_addr;
      we_d    = bus.rd_we;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end

  // Writeback is independent of the handshake and of flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_live_c) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.alu_op      = op_q;
  assign bus.out_rd_addr = rd_q;
  assign bus.out_rd_we   = we_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus random traffic against a reference model.
module tb_operand_fetch;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_if #(.AW(AW)) bus ();

  operand_fetch #(.NREGS(NR), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] m_regs [NR];
  bit          m_pend [NR];
  bit          m_valid;
  logic [31:0] m_a, m_b;
  logic [5:0]  m_op;
  logic [4:0]  m_rd;
  bit          m_we;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] addr);
    if (addr == 0) return 32'h0;
    if (bus.wb_en && bus.wb_addr == addr) return bus.wb_data;
    return m_regs[addr];
  endfunction

  function automatic bit m_busy(input logic [4:0] addr);
`ifdef OPF_SCOREBOARD_EN
    return m_pend[addr] && !(bus.wb_en && bus.wb_addr == addr);
`else
    return (addr != addr);
`endif
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = m_busy(bus.rs_addr) || (!bus.use_imm && m_busy(bus.rt_addr)) || (bus.rd_we && m_busy(bus.rd_addr));
    return !bus.flush && (!m_valid || bus.out_ready) && !hz;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_regs[i] = 32'h0; m_pend[i] = 1'b0; end
    m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_we = 0;
  endtask

  // Applies one rising edge to the reference, using the inputs presented during the cycle
  task automatic model_edge();
    bit acc;
    logic [31:0] ra, rb, ext;
    acc = bus.in_valid && m_ready();
    ra  = m_read(bus.rs_addr);
    ext = bus.sign_ext ? 32'(signed'(bus.imm)) : 32'(bus.imm);
    rb  = bus.use_imm ? ext : m_read(bus.rt_addr);
    if (bus.flush) begin
      if (m_valid && m_we) m_pend[m_rd] = 1'b0;
      m_valid = 0;
    end else if (acc) begin
      m_valid = 1; m_a = ra; m_b = rb; m_op = bus.funct; m_rd = bus.rd_addr; m_we = bus.rd_we;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
    if (bus.wb_en) begin
      m_pend[bus.wb_addr] = 1'b0;
      if (bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
    end
    if (acc && bus.rd_we && bus.rd_addr != 0) m_pend[bus.rd_addr] = 1'b1;
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("a", bus.a, m_a);
      check_eq("b", bus.b, m_b);
      check_eq("alu_op", 32'(bus.alu_op), 32'(m_op));
      check_eq("out_rd_addr", 32'(bus.out_rd_addr), 32'(m_rd));
      check_eq("out_rd_we", 32'(bus.out_rd_we), 32'(m_we));
    end
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.rs_addr = 0; bus.rt_addr = 0; bus.rd_addr = 0; bus.rd_we = 0;
    bus.use_imm = 0; bus.sign_ext = 0; bus.imm = 0; bus.funct = 0; bus.flush = 0;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.out_ready = 1;
  endtask

  // Called at a negedge with inputs driven; returns at the next negedge
  task automatic cycle();
    #1 check_eq("in_ready", 32'(bus.in_ready), 32'(m_ready()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] fn);
    bus.in_valid = 1; bus.rs_addr = rs; bus.rt_addr = rt; bus.funct = fn;
  endtask

  task automatic reset_checks();
    check_eq("rst out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("rst a", bus.a, 32'h0);
    check_eq("rst b", bus.b, 32'h0);
    check_eq("rst alu_op", 32'(bus.alu_op), 32'h0);
    check_eq("rst out_rd", 32'({bus.out_rd_we, bus.out_rd_addr}), 32'h0);
  endtask

  logic [31:0] held_a;

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    reset_checks();
    check_eq("rst in_ready", 32'(bus.in_ready), 32'h1);
    reset_n = 1;

    // Writeback then read
    bus.wb_en = 1; bus.wb_addr = 5; bus.wb_data = 32'hDEADBEEF;
    cycle();
    idle(); issue(5, 0, 6'h20);
    cycle();
    check_eq("wb read a", bus.a, 32'hDEADBEEF);
    check_eq("wb read b", bus.b, 32'h0);
    check_eq("wb read op", 32'(bus.alu_op), 32'h20);
    check_eq("wb read valid", 32'(bus.out_valid), 32'h1);

    // Immediate extension
    idle(); issue(7, 0, 6'h21); bus.use_imm = 1; bus.imm = 16'h8001; bus.sign_ext = 1;
    cycle();
    check_eq("sext b", bus.b, 32'hFFFF8001);
    bus.sign_ext = 0;
    cycle();
    check_eq("zext b", bus.b, 32'h00008001);

    // Same-edge bypass, then r0 stays zero
    idle(); issue(9, 9, 6'h22); bus.wb_en = 1; bus.wb_addr = 9; bus.wb_data = 32'h12345678;
    cycle();
    check_eq("bypass a", bus.a, 32'h12345678);
    check_eq("bypass b", bus.b, 32'h12345678);
    idle(); bus.wb_en = 1; bus.wb_addr = 0; bus.wb_data = 32'h1; issue(0, 0, 6'h23);
    cycle();
    check_eq("r0 bypass a", bus.a, 32'h0);
    idle(); issue(0, 0, 6'h24);
    cycle();
    check_eq("r0 read a", bus.a, 32'h0);
    check_eq("r0 read b", bus.b, 32'h0);

    // Backpressure stall
    held_a = bus.a;
    idle(); issue(5, 9, 6'h25); bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("stall in_ready", 32'(bus.in_ready), 32'h0);
      cycle();
      check_eq("stall a", bus.a, held_a);
      check_eq("stall op", 32'(bus.alu_op), 32'h24);
    end
    bus.out_ready = 1;
    cycle();
    check_eq("release valid", 32'(bus.out_valid), 32'h1);
    check_eq("release a", bus.a, 32'hDEADBEEF);
    check_eq("release b", bus.b, 32'h12345678);

    // Flush
    bus.flush = 1;
    #1 check_eq("flush in_ready", 32'(bus.in_ready), 32'h0);
    cycle();
    check_eq("flush valid", 32'(bus.out_valid), 32'h0);

    // Async reset mid-stall
    idle(); issue(9, 5, 6'h26);
    cycle();
    idle(); bus.out_ready = 0;
    cycle();
    #2 reset_n = 0;
    #1 check_eq("async rst valid", 32'(bus.out_valid), 32'h0);
    model_reset();
    reset_checks();
    @(negedge clk);
    reset_n = 1;
    idle(); issue(5, 9, 6'h27);
    cycle();
    check_eq("cleared a", bus.a, 32'h0);
    check_eq("cleared b", bus.b, 32'h0);

`ifdef OPF_SCOREBOARD_EN
    // RAW hazard held until writeback of the pending register
    idle(); issue(0, 0, 6'h28); bus.rd_addr = 3; bus.rd_we = 1;
    cycle();
    idle(); issue(3, 0, 6'h29);
    for (int i = 0; i < 2; i++) begin
      #1 check_eq("sb hazard", 32'(bus.in_ready), 32'h0);
      cycle();
    end
    bus.wb_en = 1; bus.wb_addr = 3; bus.wb_data = 32'hCAFEF00D;
    #1 check_eq("sb release", 32'(bus.in_ready), 32'h1);
    cycle();
    check_eq("sb bypass a", bus.a, 32'hCAFEF00D);
    check_eq("sb op", 32'(bus.alu_op), 32'h29);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.rs_addr   = 5'($urandom_range(0, 7));
      bus.rt_addr   = 5'($urandom_range(0, 7));
      bus.rd_addr   = 5'($urandom_range(0, 7));
      bus.rd_we     = 1'($urandom_range(0, 1));
      bus.use_imm   = 1'($urandom_range(0, 1));
      bus.sign_ext  = 1'($urandom_range(0, 1));
      bus.imm       = 16'($urandom);
      bus.funct     = 6'($urandom);
      bus.flush     = ($urandom_range(0, 9) == 0);
      bus.wb_en     = 1'($urandom_range(0, 1));
      bus.wb_addr   = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
